// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter and its decoder.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_BUSY,
        ST_RESP
    } state_t;

    // Slave index doubles as the bit position in the one-hot select.
    typedef enum logic [1:0] {
        SLV_RAM    = 2'd0,
        SLV_STDOUT = 2'd1,
        SLV_STDIN  = 2'd2,
        SLV_LFSR   = 2'd3
    } slave_t;

    localparam int unsigned NUM_SLAVES    = 4;

    localparam int unsigned IO_OFF_STDOUT = 0;
    localparam int unsigned IO_OFF_STDIN  = 4;
    localparam int unsigned IO_OFF_LFSR   = 8;

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input slave_t s);
        return NUM_SLAVES'(1) << s;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response bundle of one bus master (addr/size/valid/write/wdata/rdata/ready/err).
interface bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic          valid;
    logic          write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          err;

    modport master (
        output addr, size, valid, write, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, size, valid, write, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/bus_decode.sv
// Combinational address decode: one-hot slave select, mapped flag, slave-local address.
module bus_decode
    import bus_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned RAM_BASE = 'h1000,
    parameter int unsigned RAM_END  = 'h2000,
    parameter int unsigned IO_BASE  = 'h3000
) (
    input  logic [AW-1:0]         addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  mapped,
    output logic [AW-1:0]         offset
);

    localparam logic [AW-1:0] RAM_LO  = AW'(RAM_BASE);
    localparam logic [AW-1:0] RAM_HI  = AW'(RAM_END);
    localparam logic [AW-1:0] IO_OUT  = AW'(IO_BASE + IO_OFF_STDOUT);
    localparam logic [AW-1:0] IO_IN   = AW'(IO_BASE + IO_OFF_STDIN);
    localparam logic [AW-1:0] IO_LFSR = AW'(IO_BASE + IO_OFF_LFSR);

    // RAM is a half-open window rebased to zero; IO words match exactly and pass through.
    always_comb begin
        sel    = '0;
        mapped = 1'b0;
        offset = addr;
        if (addr >= RAM_LO && addr < RAM_HI) begin
            sel    = slave_onehot(SLV_RAM);
            mapped = 1'b1;
            offset = addr - RAM_LO;
        end else if (addr == IO_OUT) begin
            sel    = slave_onehot(SLV_STDOUT);
            mapped = 1'b1;
        end else if (addr == IO_IN) begin
            sel    = slave_onehot(SLV_STDIN);
            mapped = 1'b1;
        end else if (addr == IO_LFSR) begin
            sel    = slave_onehot(SLV_LFSR);
            mapped = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with slave decode and bus-timeout error response.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned RAM_BASE = 'h1000,
    parameter int unsigned RAM_END  = 'h2000,
    parameter int unsigned IO_BASE  = 'h3000
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_arbiter_if.slave          m0,
    bus_arbiter_if.slave          m1,
    output logic [AW-1:0]         s_addr,
    output logic [2:0]            s_size,
    output logic                  s_write,
    output logic [DW-1:0]         s_wdata,
    output logic [NUM_SLAVES-1:0] s_sel,
    output logic                  s_valid,
    input  logic [NUM_SLAVES-1:0] s_ready,
    input  logic [DW-1:0]         s_rdata_ram,
    input  logic [DW-1:0]         s_rdata_in,
    input  logic [DW-1:0]         s_rdata_lfsr
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t                state, state_n;
    logic                  gnt, gnt_n;       // 0 = m0, 1 = m1
    logic                  last, last_n;     // master served most recently
    logic [7:0]            cnt, cnt_n;
    logic                  resp_ready, resp_ready_n;
    logic                  resp_err, resp_err_n;
    logic [DW-1:0]         resp_rdata, resp_rdata_n;
    logic [AW-1:0]         s_addr_n;
    logic [2:0]            s_size_n;
    logic                  s_write_n;
    logic [DW-1:0]         s_wdata_n;
    logic [NUM_SLAVES-1:0] s_sel_n;
    logic                  s_valid_n;

    logic                  pick;
    logic                  any_valid;
    logic [AW-1:0]         req_addr;
    logic [2:0]            req_size;
    logic                  req_write;
    logic [DW-1:0]         req_wdata;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_mapped;
    logic [AW-1:0]         dec_offset;
    logic [DW-1:0]         sel_rdata;

    // Round-robin pick: on a tie the master not served last wins.
    always_comb begin
        any_valid = m0.valid | m1.valid;
        if (m0.valid && m1.valid) begin
            pick = ~last;
        end else begin
            pick = m1.valid;
        end
        req_addr  = pick ? m1.addr  : m0.addr;
        req_size  = pick ? m1.size  : m0.size;
        req_write = pick ? m1.write : m0.write;
        req_wdata = pick ? m1.wdata : m0.wdata;
    end

    bus_decode #(
        .AW       (AW),
        .RAM_BASE (RAM_BASE),
        .RAM_END  (RAM_END),
        .IO_BASE  (IO_BASE)
    ) u_decode (
        .addr   (req_addr),
        .sel    (dec_sel),
        .mapped (dec_mapped),
        .offset (dec_offset)
    );

    // Read-data mux for the currently selected slave; stdout has no read path.
    always_comb begin
        sel_rdata = '0;
        if (s_sel[SLV_RAM]) begin
            sel_rdata = s_rdata_ram;
        end else if (s_sel[SLV_STDIN]) begin
            sel_rdata = s_rdata_in;
        end else if (s_sel[SLV_LFSR]) begin
            sel_rdata = s_rdata_lfsr;
        end
    end

    // Next-state and next-register values; all outputs are registered from these.
    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        last_n       = last;
        cnt_n        = cnt;
        s_addr_n     = s_addr;
        s_size_n     = s_size;
        s_write_n    = s_write;
        s_wdata_n    = s_wdata;
        s_sel_n      = s_sel;
        s_valid_n    = s_valid;
        resp_ready_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        unique case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_n = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!any_valid) begin
                    state_n = ST_IDLE;
                end else begin
                    gnt_n = pick;
                    if (dec_mapped) begin
                        state_n   = ST_BUSY;
                        s_addr_n  = dec_offset;
                        s_size_n  = req_size;
                        s_write_n = req_write;
                        s_wdata_n = req_wdata;
                        s_sel_n   = dec_sel;
                        s_valid_n = 1'b1;
                        cnt_n     = '0;
                    end else begin
                        state_n      = ST_RESP;
                        resp_ready_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // Slave ready is checked first so it wins over a same-cycle timeout.
                if (|(s_ready & s_sel)) begin
                    state_n      = ST_RESP;
                    s_valid_n    = 1'b0;
                    s_sel_n      = '0;
                    resp_ready_n = 1'b1;
                    resp_rdata_n = s_write ? '0 : sel_rdata;
                end else if (cnt == TO_LIMIT) begin
                    state_n      = ST_RESP;
                    s_valid_n    = 1'b0;
                    s_sel_n      = '0;
                    resp_ready_n = 1'b1;
                    resp_err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_RESP: begin
                last_n  = gnt;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            s_addr     <= '0;
            s_size     <= '0;
            s_write    <= 1'b0;
            s_wdata    <= '0;
            s_sel      <= '0;
            s_valid    <= 1'b0;
            resp_ready <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            last       <= last_n;
            cnt        <= cnt_n;
            s_addr     <= s_addr_n;
            s_size     <= s_size_n;
            s_write    <= s_write_n;
            s_wdata    <= s_wdata_n;
            s_sel      <= s_sel_n;
            s_valid    <= s_valid_n;
            resp_ready <= resp_ready_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
        end
    end

    assign m0.ready = resp_ready & ~gnt;
    assign m0.err   = resp_err & ~gnt;
    assign m0.rdata = gnt ? '0 : resp_rdata;
    assign m1.ready = resp_ready & gnt;
    assign m1.err   = resp_err & gnt;
    assign m1.rdata = gnt ? resp_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single read, tie fairness, unmapped, timeout, reset abort, stdout write.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    logic        s_write;
    logic [31:0] s_wdata;
    logic [3:0]  s_sel;
    logic        s_valid;
    logic [3:0]  s_ready;
    logic [31:0] s_rdata_ram;
    logic [31:0] s_rdata_in;
    logic [31:0] s_rdata_lfsr;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
    bus_arbiter_if #(.AW(32), .DW(32)) m1_bus ();

    bus_arbiter #(
        .AW       (32),
        .DW       (32),
        .TIMEOUT  (8),
        .RAM_BASE ('h1000),
        .RAM_END  ('h2000),
        .IO_BASE  ('h3000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .s_addr       (s_addr),
        .s_size       (s_size),
        .s_write      (s_write),
        .s_wdata      (s_wdata),
        .s_sel        (s_sel),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_rdata_ram  (s_rdata_ram),
        .s_rdata_in   (s_rdata_in),
        .s_rdata_lfsr (s_rdata_lfsr)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_bus.addr = '0; m0_bus.size = '0; m0_bus.valid = 1'b0; m0_bus.write = 1'b0; m0_bus.wdata = '0;
        m1_bus.addr = '0; m1_bus.size = '0; m1_bus.valid = 1'b0; m1_bus.write = 1'b0; m1_bus.wdata = '0;
        s_ready = '0;
        s_rdata_ram = 32'h1111_1111;
        s_rdata_in = 32'h2222_2222;
        s_rdata_lfsr = 32'h3333_3333;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (m0_bus.ready !== 1'b0) $display("FAIL reset_m0_ready: got %b want 0", m0_bus.ready); else passes++;
        checks++; if (m1_bus.ready !== 1'b0) $display("FAIL reset_m1_ready: got %b want 0", m1_bus.ready); else passes++;
        checks++; if (m0_bus.err !== 1'b0) $display("FAIL reset_m0_err: got %b want 0", m0_bus.err); else passes++;
        checks++; if (s_valid !== 1'b0) $display("FAIL reset_s_valid: got %b want 0", s_valid); else passes++;
        checks++; if (s_sel !== 4'b0000) $display("FAIL reset_s_sel: got %b want 0000", s_sel); else passes++;
        checks++; if (m0_bus.rdata !== 32'h0) $display("FAIL reset_m0_rdata: got %h want 0", m0_bus.rdata); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        m0_bus.addr = 32'h1004; m0_bus.size = 3'd2; m0_bus.write = 1'b0; m0_bus.valid = 1'b1;
        step();
        checks++; if (s_valid !== 1'b0) $display("FAIL read_s_valid_early: got %b want 0", s_valid); else passes++;
        step();
        checks++; if (s_valid !== 1'b1) $display("FAIL read_s_valid: got %b want 1", s_valid); else passes++;
        checks++; if (s_addr !== 32'h4) $display("FAIL read_s_addr: got %h want 4", s_addr); else passes++;
        checks++; if (s_sel !== 4'b0001) $display("FAIL read_s_sel: got %b want 0001", s_sel); else passes++;
        checks++; if (s_size !== 3'd2) $display("FAIL read_s_size: got %0d want 2", s_size); else passes++;
        s_ready = 4'b0001; s_rdata_ram = 32'hCAFE_0001;
        step();
        checks++; if (m0_bus.ready !== 1'b1) $display("FAIL read_m0_ready: got %b want 1", m0_bus.ready); else passes++;
        checks++; if (m0_bus.rdata !== 32'hCAFE_0001) $display("FAIL read_m0_rdata: got %h want cafe0001", m0_bus.rdata); else passes++;
        checks++; if (m0_bus.err !== 1'b0) $display("FAIL read_m0_err: got %b want 0", m0_bus.err); else passes++;
        checks++; if (m1_bus.ready !== 1'b0) $display("FAIL read_m1_ready: got %b want 0", m1_bus.ready); else passes++;
        checks++; if (s_valid !== 1'b0) $display("FAIL read_s_valid_after: got %b want 0", s_valid); else passes++;
        m0_bus.valid = 1'b0; s_ready = '0;
        step();
        checks++; if (m0_bus.ready !== 1'b0) $display("FAIL read_ready_pulse: got %b want 0", m0_bus.ready); else passes++;
    endtask

    task automatic test_tie_fairness();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_bus.addr = 32'h1000; m0_bus.size = 3'd2; m0_bus.write = 1'b0; m0_bus.valid = 1'b1;
        m1_bus.addr = 32'h1100; m1_bus.size = 3'd2; m1_bus.write = 1'b0; m1_bus.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            logic [31:0] exp_addr;
            logic [31:0] exp_data;
            while (s_valid !== 1'b1 && n < 6) begin
                step();
                n++;
            end
            checks++; if (s_valid !== 1'b1) $display("FAIL tie_wait_s_valid[%0d]: got %b want 1 within 6 cycles", i, s_valid); else passes++;
            exp_addr = (i % 2 == 0) ? 32'h000 : 32'h100;
            exp_data = 32'hA000_0000 + 32'(i);
            checks++; if (s_addr !== exp_addr) $display("FAIL tie_grant_addr[%0d]: got %h want %h", i, s_addr, exp_addr); else passes++;
            s_ready = 4'b0001; s_rdata_ram = exp_data;
            step();
            s_ready = '0;
            if (i % 2 == 0) begin
                checks++; if (m0_bus.ready !== 1'b1 || m1_bus.ready !== 1'b0)
                    $display("FAIL tie_ready[%0d]: got m0=%b m1=%b want m0=1 m1=0", i, m0_bus.ready, m1_bus.ready); else passes++;
                checks++; if (m0_bus.rdata !== exp_data) $display("FAIL tie_rdata[%0d]: got %h want %h", i, m0_bus.rdata, exp_data); else passes++;
            end else begin
                checks++; if (m1_bus.ready !== 1'b1 || m0_bus.ready !== 1'b0)
                    $display("FAIL tie_ready[%0d]: got m0=%b m1=%b want m0=0 m1=1", i, m0_bus.ready, m1_bus.ready); else passes++;
                checks++; if (m1_bus.rdata !== exp_data) $display("FAIL tie_rdata[%0d]: got %h want %h", i, m1_bus.rdata, exp_data); else passes++;
            end
            if (i == 3) begin
                m0_bus.valid = 1'b0;
                m1_bus.valid = 1'b0;
            end
        end
        step();
    endtask

    task automatic test_unmapped();
        m1_bus.addr = 32'h2800; m1_bus.size = 3'd2; m1_bus.write = 1'b1; m1_bus.wdata = 32'h77; m1_bus.valid = 1'b1;
        step();
        checks++; if (m1_bus.ready !== 1'b0) $display("FAIL unmap_ready_early: got %b want 0", m1_bus.ready); else passes++;
        checks++; if (s_valid !== 1'b0) $display("FAIL unmap_s_valid_1: got %b want 0", s_valid); else passes++;
        step();
        checks++; if (m1_bus.ready !== 1'b1) $display("FAIL unmap_m1_ready: got %b want 1", m1_bus.ready); else passes++;
        checks++; if (m1_bus.err !== 1'b1) $display("FAIL unmap_m1_err: got %b want 1", m1_bus.err); else passes++;
        checks++; if (s_valid !== 1'b0) $display("FAIL unmap_s_valid_2: got %b want 0", s_valid); else passes++;
        checks++; if (m0_bus.ready !== 1'b0) $display("FAIL unmap_m0_ready: got %b want 0", m0_bus.ready); else passes++;
        m1_bus.valid = 1'b0;
        step();
        checks++; if (s_valid !== 1'b0 || m1_bus.ready !== 1'b0)
            $display("FAIL unmap_after: got s_valid=%b ready=%b want 0 0", s_valid, m1_bus.ready); else passes++;
    endtask

    task automatic test_timeout();
        int k;
        int busy;
        m0_bus.addr = 32'h3004; m0_bus.size = 3'd2; m0_bus.write = 1'b0; m0_bus.valid = 1'b1;
        s_ready = 4'b1011;
        s_rdata_in = 32'hDEAD_BEEF;
        busy = 0;
        for (k = 1; k <= 20; k++) begin
            step();
            if (k == 2) begin
                checks++; if (s_sel !== 4'b0100) $display("FAIL timeout_s_sel: got %b want 0100", s_sel); else passes++;
                checks++; if (s_addr !== 32'h3004) $display("FAIL timeout_s_addr: got %h want 3004", s_addr); else passes++;
            end
            if (s_valid === 1'b1) busy++;
            if (m0_bus.ready === 1'b1) break;
        end
        checks++; if (k != 11) $display("FAIL timeout_ready_cycle: got %0d want 11", k); else passes++;
        checks++; if (busy != 9) $display("FAIL timeout_busy_cycles: got %0d want 9", busy); else passes++;
        checks++; if (m0_bus.err !== 1'b1) $display("FAIL timeout_err: got %b want 1", m0_bus.err); else passes++;
        checks++; if (m0_bus.rdata !== 32'h0) $display("FAIL timeout_rdata: got %h want 0", m0_bus.rdata); else passes++;
        m0_bus.valid = 1'b0; s_ready = '0;
        step();
        checks++; if (s_valid !== 1'b0 || m0_bus.ready !== 1'b0)
            $display("FAIL timeout_after: got s_valid=%b ready=%b want 0 0", s_valid, m0_bus.ready); else passes++;
    endtask

    task automatic test_timeout_race();
        int k;
        m0_bus.addr = 32'h3008; m0_bus.size = 3'd2; m0_bus.write = 1'b0; m0_bus.valid = 1'b1;
        s_rdata_lfsr = 32'h1234_5678;
        s_ready = '0;
        for (k = 1; k <= 20; k++) begin
            step();
            if (m0_bus.ready === 1'b1) break;
            if (k == 10) s_ready = 4'b1000;
        end
        checks++; if (k != 11) $display("FAIL race_ready_cycle: got %0d want 11", k); else passes++;
        checks++; if (m0_bus.err !== 1'b0) $display("FAIL race_err: got %b want 0", m0_bus.err); else passes++;
        checks++; if (m0_bus.rdata !== 32'h1234_5678) $display("FAIL race_rdata: got %h want 12345678", m0_bus.rdata); else passes++;
        m0_bus.valid = 1'b0; s_ready = '0;
        step();
    endtask

    task automatic test_reset_in_busy();
        m0_bus.addr = 32'h1010; m0_bus.size = 3'd2; m0_bus.write = 1'b1; m0_bus.wdata = 32'h55; m0_bus.valid = 1'b1;
        step();
        step();
        checks++; if (s_valid !== 1'b1 || s_write !== 1'b1 || s_wdata !== 32'h55 || s_addr !== 32'h10)
            $display("FAIL rstbusy_issue: got valid=%b write=%b wdata=%h addr=%h want 1 1 55 10", s_valid, s_write, s_wdata, s_addr); else passes++;
        rst = 1'b1;
        m0_bus.valid = 1'b0;
        s_ready = 4'b0001;
        step();
        s_ready = '0;
        checks++; if (s_valid !== 1'b0) $display("FAIL rstbusy_s_valid: got %b want 0", s_valid); else passes++;
        checks++; if (m0_bus.ready !== 1'b0) $display("FAIL rstbusy_m0_ready: got %b want 0", m0_bus.ready); else passes++;
        checks++; if (s_sel !== 4'b0000) $display("FAIL rstbusy_s_sel: got %b want 0000", s_sel); else passes++;
        rst = 1'b0;
        step();
        checks++; if (m0_bus.ready !== 1'b0) $display("FAIL rstbusy_no_late_ready: got %b want 0", m0_bus.ready); else passes++;
        m0_bus.addr = 32'h1020; m0_bus.write = 1'b0; m0_bus.valid = 1'b1;
        m1_bus.addr = 32'h1030; m1_bus.size = 3'd2; m1_bus.write = 1'b0; m1_bus.valid = 1'b1;
        step();
        step();
        checks++; if (s_addr !== 32'h20) $display("FAIL rstbusy_tie_winner: got s_addr=%h want 20", s_addr); else passes++;
        s_ready = 4'b0001; s_rdata_ram = 32'h600D;
        step();
        checks++; if (m0_bus.ready !== 1'b1 || m1_bus.ready !== 1'b0)
            $display("FAIL rstbusy_fresh_ready: got m0=%b m1=%b want 1 0", m0_bus.ready, m1_bus.ready); else passes++;
        checks++; if (m0_bus.rdata !== 32'h600D) $display("FAIL rstbusy_fresh_rdata: got %h want 600d", m0_bus.rdata); else passes++;
        m0_bus.valid = 1'b0; m1_bus.valid = 1'b0; s_ready = '0;
        step();
    endtask

    task automatic test_stdout_write();
        m1_bus.addr = 32'h3000; m1_bus.size = 3'd0; m1_bus.write = 1'b1; m1_bus.wdata = 32'h41; m1_bus.valid = 1'b1;
        s_rdata_ram = 32'h9999_9999; s_rdata_in = 32'h8888_8888; s_rdata_lfsr = 32'h7777_7777;
        step();
        step();
        checks++; if (s_sel !== 4'b0010) $display("FAIL stdout_s_sel: got %b want 0010", s_sel); else passes++;
        checks++; if (s_wdata !== 32'h41) $display("FAIL stdout_s_wdata: got %h want 41", s_wdata); else passes++;
        checks++; if (s_addr !== 32'h3000 || s_write !== 1'b1)
            $display("FAIL stdout_s_addr: got addr=%h write=%b want 3000 1", s_addr, s_write); else passes++;
        s_ready = 4'b0010;
        step();
        s_ready = '0;
        checks++; if (m1_bus.ready !== 1'b1) $display("FAIL stdout_m1_ready: got %b want 1", m1_bus.ready); else passes++;
        checks++; if (m1_bus.rdata !== 32'h0) $display("FAIL stdout_m1_rdata: got %h want 0", m1_bus.rdata); else passes++;
        checks++; if (m1_bus.err !== 1'b0 || m0_bus.ready !== 1'b0)
            $display("FAIL stdout_err: got err=%b m0_ready=%b want 0 0", m1_bus.err, m0_bus.ready); else passes++;
        m1_bus.valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie_fairness();
        test_unmapped();
        test_timeout();
        test_timeout_race();
        test_reset_in_busy();
        test_stdout_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master round-robin arbiter and slave decoder for the core's `addr/size/valid/write/wdata/rdata/ready` memory bus. It lets a CPU core (m0) and a second requester such as a loader or DMA (m1) share the RAM window and the memory-mapped stdout, stdin and LFSR ports. It also adds address decode and a bus-timeout error response. It replaces the ad-hoc ready/rdata muxing that benches currently do by hand.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 255: maximum BUSY cycles before an error response; 8-bit counter.
- `RAM_BASE`, default 'h1000: RAM window base; the window is [RAM_BASE, RAM_END).
- `RAM_END`, default 'h2000: RAM window end (exclusive).
- `IO_BASE`, default 'h3000: stdout at +0, stdin at +4, LFSR at +8.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `m0_addr`/`m1_addr` in AW: request address.
- `m0_size`/`m1_size` in 3: transfer size.
- `m0_valid`/`m1_valid` in 1: request; held with all fields stable until ready.
- `m0_write`/`m1_write` in 1: 1 = write.
- `m0_wdata`/`m1_wdata` in DW: write data.
- `m0_rdata`/`m1_rdata` out DW: read data; valid in the ready cycle.
- `m0_ready`/`m1_ready` out 1: one-cycle completion pulse.
- `m0_err`/`m1_err` out 1: qualifies ready; 1 = unmapped address or timeout.
- `s_addr` out AW: slave-side copy of the granted master's field; RAM offset already subtracted for the RAM slave.
- `s_size` out 3: granted master's size.
- `s_write` out 1: granted master's write flag.
- `s_wdata` out DW: granted master's write data.
- `s_sel` out 4: one-hot slave select; bit 0 RAM, 1 stdout, 2 stdin, 3 LFSR.
- `s_valid` out 1: slave request.
- `s_ready` in 4: per-slave ready.
- `s_rdata_ram`, `s_rdata_in`, `s_rdata_lfsr` in DW: read data from each slave; stdout reads return 0.

## Operation
- FSM states: IDLE, ARB, BUSY, RESP.
- IDLE:
  - Any `mX_valid` → ARB.
- ARB (1 cycle):
  - Choose the master. If only one is valid, grant it. If both are valid, grant the master not served last (pointer `last`).
  - Decode the granted address.
  - Mapped address → BUSY, with `s_valid`=1 and `s_sel` set.
  - Unmapped address → RESP with err=1.
- BUSY:
  - Drive `s_*` from the granted master.
  - `s_ready[sel]`=1 → capture rdata (0 on writes), → RESP.
  - Timeout counter reaches TIMEOUT → drop `s_valid`, set err=1, rdata=0, → RESP.
- RESP (1 cycle):
  - Pulse `mG_ready`, `mG_err`, `mG_rdata` for the granted master G.
  - Set `last` = G.
  - → IDLE.
- The non-granted master never sees ready. Its request simply waits.
- `s_addr` for RAM = addr − RAM_BASE. For IO slaves it is passed through unchanged.
- Decode is exact-match on the IO addresses. Anything outside RAM and the three IO words is unmapped.
- Holding valid after ready is a new request, re-arbitrated from IDLE.

## Timing
- Reset values:
  - all `mX_ready`, `mX_err`, `s_valid` = 0;
  - `mX_rdata` = 0;
  - `s_sel` = 0;
  - `last` = m1, so m0 wins the first tie;
  - state IDLE, timeout counter 0.
- Reset mid-transaction: everything above returns to reset values on the next edge. `s_valid` falls in the same cycle reset is sampled. No ready is produced for the aborted request.
- Latency from `mX_valid` rising to `s_valid`: 2 cycles (IDLE sample, then ARB).
- Latency from `s_ready` to `mX_ready`: 1 cycle.
- Minimum transaction is 4 cycles, with a zero-wait slave.
- Unmapped access: `mX_ready`+err 2 cycles after the request is sampled.
- The timeout counter clears on entry to BUSY. Error fires when the count equals TIMEOUT (TIMEOUT+1 BUSY cycles).
- `s_ready` on a non-selected bit is ignored.
- `s_ready` in the same cycle as timeout: ready wins, err=0.
- `s_*` outputs are registered. They are held constant for the whole of BUSY.

## Structure
- `bus_pkg`:
  - state enum;
  - slave index enum (RAM, STDOUT, STDIN, LFSR);
  - IO offset constants (0, 4, 8).
- Sub-module `bus_decode`: combinational address → {one-hot sel, mapped flag, offset addr}. It is reused by future single-master benches.
- Top contains the FSM, round-robin pointer, timeout counter and response registers.

## Test plan
- **Single read:** m0 reads 'h1004 with RAM ready 1 cycle later. Required: `s_addr`='h004, `s_sel`=0001, `m0_ready` at cycle 4 with RAM data, err=0.
- **Tie fairness:** m0 and m1 both hold valid for 4 transactions. Required: grants alternate m0, m1, m0, m1; the first grant goes to m0 after reset.
- **Unmapped access:** m1 writes 'h2800. Required: `s_valid` never asserts; `m1_ready`=1, `m1_err`=1 two cycles after the request.
- **Timeout:** m0 reads 'h3004 with `s_ready` held 0 and TIMEOUT=8. Required: `m0_ready`+err after 9 BUSY cycles, rdata=0, `s_valid` low afterwards.
- **Reset in BUSY:** `rst`=1 mid-RAM-write. Required: `s_valid`=0 and no `m0_ready`. After release, a fresh m0 request completes normally and a tie is won by m0.
- **Stdout write:** m1 writes 'h41 to 'h3000. Required: `s_sel`=0010, `s_wdata`='h41, `m1_rdata`=0 on ready.
